// File: rtl/pipe_reg_skid.sv
// Flow-controlled write-back pipeline stage register with a 2-entry skid buffer,
// synchronous flush, x0-write suppression and a saturating stall counter.
module pipe_reg_skid #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTRL_W = 3,
  parameter int unsigned RD_W   = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_regwrite,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_alu,
  input  logic [DATA_W-1:0] in_mem,
  input  logic [RD_W-1:0]   in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_regwrite,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_alu,
  output logic [DATA_W-1:0] out_mem,
  output logic [RD_W-1:0]   out_rd,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic              r_main_valid;
  logic              r_skid_valid;
  logic              r_in_ready;
  logic              r_out_regwrite;

  logic              r_main_rw;
  logic [CTRL_W-1:0] r_main_ctrl;
  logic [DATA_W-1:0] r_main_alu;
  logic [DATA_W-1:0] r_main_mem;
  logic [RD_W-1:0]   r_main_rd;

  logic              r_skid_rw;
  logic [CTRL_W-1:0] r_skid_ctrl;
  logic [DATA_W-1:0] r_skid_alu;
  logic [DATA_W-1:0] r_skid_mem;
  logic [RD_W-1:0]   r_skid_rd;

  logic [CNT_W-1:0]  r_stall_cnt;

  logic              w_accept;
  logic              w_xfer;
  logic              w_in_rw;
  logic              w_stall;
  logic              w_main_valid_nxt;
  logic              w_skid_valid_nxt;
  logic              w_main_rw_nxt;
  logic              w_ld_main_in;
  logic              w_ld_main_skid;
  logic              w_ld_skid;

  assign w_accept = in_valid & r_in_ready;
  assign w_xfer   = r_main_valid & out_ready;
  // Writes to register 0 are dropped at capture so they can never be issued.
  assign w_in_rw  = in_regwrite & (in_rd != '0);
  assign w_stall  = r_main_valid & ~out_ready;

  // Occupancy and load-select decode; flush overrides every other update.
  always_comb begin
    w_main_valid_nxt = r_main_valid;
    w_skid_valid_nxt = r_skid_valid;
    w_ld_main_in     = 1'b0;
    w_ld_main_skid   = 1'b0;
    w_ld_skid        = 1'b0;

    if (flush) begin
      w_main_valid_nxt = 1'b0;
      w_skid_valid_nxt = 1'b0;
    end else if (!r_main_valid) begin
      if (w_accept) begin
        w_main_valid_nxt = 1'b1;
        w_ld_main_in     = 1'b1;
      end
    end else if (w_xfer) begin
      if (r_skid_valid) begin
        w_ld_main_skid   = 1'b1;
        w_skid_valid_nxt = 1'b0;
      end else if (w_accept) begin
        w_ld_main_in     = 1'b1;
      end else begin
        w_main_valid_nxt = 1'b0;
      end
    end else if (w_accept) begin
      w_ld_skid        = 1'b1;
      w_skid_valid_nxt = 1'b1;
    end
  end

  always_comb begin
    w_main_rw_nxt = r_main_rw;
    if (w_ld_main_in) begin
      w_main_rw_nxt = w_in_rw;
    end else if (w_ld_main_skid) begin
      w_main_rw_nxt = r_skid_rw;
    end
  end

  // Valid bits, registered handshake outputs and stall counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_main_valid   <= 1'b0;
      r_skid_valid   <= 1'b0;
      r_in_ready     <= 1'b1;
      r_out_regwrite <= 1'b0;
      r_stall_cnt    <= '0;
    end else begin
      r_main_valid   <= w_main_valid_nxt;
      r_skid_valid   <= w_skid_valid_nxt;
      r_in_ready     <= ~w_skid_valid_nxt;
      r_out_regwrite <= w_main_valid_nxt & w_main_rw_nxt;
      if (w_stall && (r_stall_cnt != CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
    end
  end

  // Payload storage for the main and skid entries.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_main_rw   <= 1'b0;
      r_main_ctrl <= '0;
      r_main_alu  <= '0;
      r_main_mem  <= '0;
      r_main_rd   <= '0;
      r_skid_rw   <= 1'b0;
      r_skid_ctrl <= '0;
      r_skid_alu  <= '0;
      r_skid_mem  <= '0;
      r_skid_rd   <= '0;
    end else begin
      if (w_ld_main_in) begin
        r_main_rw   <= w_in_rw;
        r_main_ctrl <= in_ctrl;
        r_main_alu  <= in_alu;
        r_main_mem  <= in_mem;
        r_main_rd   <= in_rd;
      end else if (w_ld_main_skid) begin
        r_main_rw   <= r_skid_rw;
        r_main_ctrl <= r_skid_ctrl;
        r_main_alu  <= r_skid_alu;
        r_main_mem  <= r_skid_mem;
        r_main_rd   <= r_skid_rd;
      end
      if (w_ld_skid) begin
        r_skid_rw   <= w_in_rw;
        r_skid_ctrl <= in_ctrl;
        r_skid_alu  <= in_alu;
        r_skid_mem  <= in_mem;
        r_skid_rd   <= in_rd;
      end
    end
  end

  assign in_ready     = r_in_ready;
  assign out_valid    = r_main_valid;
  assign out_regwrite = r_out_regwrite;
  assign out_ctrl     = r_main_ctrl;
  assign out_alu      = r_main_alu;
  assign out_mem      = r_main_mem;
  assign out_rd       = r_main_rd;
  assign stall_cnt    = r_stall_cnt;

endmodule

// File: tb/tb_pipe_reg_skid.sv
// Scoreboard bench for pipe_reg_skid: accepted entries are queued, a negedge
// monitor pops and compares every delivered output.
module tb_pipe_reg_skid;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CTRL_W = 3;
  localparam int unsigned RD_W   = 5;
  localparam int unsigned CNT_W  = 4;

  logic              clk;
  logic              reset;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic              in_regwrite;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_alu;
  logic [DATA_W-1:0] in_mem;
  logic [RD_W-1:0]   in_rd;
  logic              out_valid;
  logic              out_ready;
  logic              out_regwrite;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_alu;
  logic [DATA_W-1:0] out_mem;
  logic [RD_W-1:0]   out_rd;
  logic [CNT_W-1:0]  stall_cnt;

  typedef struct packed {
    logic              rw;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] mem;
    logic [RD_W-1:0]   rd;
  } ent_t;

  ent_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  pipe_reg_skid #(
    .DATA_W(DATA_W), .CTRL_W(CTRL_W), .RD_W(RD_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_regwrite(in_regwrite),
    .in_ctrl(in_ctrl), .in_alu(in_alu), .in_mem(in_mem), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_regwrite(out_regwrite),
    .out_ctrl(out_ctrl), .out_alu(out_alu), .out_mem(out_mem), .out_rd(out_rd),
    .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Offer one entry and hold it until accepted; expected payload goes to the scoreboard.
  task automatic send(input logic [31:0] alu, input logic [4:0] rd, input logic rw);
    ent_t e;
    int   n;
    in_valid    = 1'b1;
    in_alu      = alu;
    in_mem      = ~alu;
    in_ctrl     = alu[2:0];
    in_rd       = rd;
    in_regwrite = rw;
    e.rw   = rw && (rd != 5'd0);
    e.ctrl = alu[2:0];
    e.alu  = alu;
    e.mem  = ~alu;
    e.rd   = rd;
    for (n = 0; n < 50; n++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    chk("send_accept", 32'(n < 50), 32'd1);
    if (n < 50) sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain;
    for (int i = 0; i < 40 && sb.size() != 0; i++) step;
    chk("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  // Monitor: every delivered entry must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid && out_ready) begin
        ent_t act;
        ent_t exp;
        act = '{rw: out_regwrite, ctrl: out_ctrl, alu: out_alu, mem: out_mem, rd: out_rd};
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_out: got alu=%0h rd=%0h with nothing expected", out_alu, out_rd);
        end else begin
          exp = sb.pop_front();
          if (act !== exp) begin
            n_err++;
            $display("FAIL out_entry: got rw=%0b ctrl=%0h alu=%0h mem=%0h rd=%0h expected rw=%0b ctrl=%0h alu=%0h mem=%0h rd=%0h",
                     act.rw, act.ctrl, act.alu, act.mem, act.rd,
                     exp.rw, exp.ctrl, exp.alu, exp.mem, exp.rd);
          end
        end
      end
      if (!out_valid) chk("bubble_regwrite", 32'(out_regwrite), 32'd0);
    end
  end

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_regwrite = 1'b0;
    in_ctrl = '0; in_alu = '0; in_mem = '0; in_rd = '0; out_ready = 1'b0;
    repeat (2) step;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_regwrite", 32'(out_regwrite), 32'd0);
    chk("rst_stall", 32'(stall_cnt), 32'd0);
    reset = 1'b0;

    // Streaming at full rate
    out_ready = 1'b1;
    step;
    send(32'd1, 5'd1, 1'b1);
    chk("t1_latency_valid", 32'(out_valid), 32'd1);
    chk("t1_first_alu", out_alu, 32'd1);
    for (int i = 2; i <= 8; i++) begin
      send(32'(i), 5'd1, 1'b1);
      chk("t1_in_ready", 32'(in_ready), 32'd1);
      chk("t1_no_gap", 32'(out_valid), 32'd1);
      chk("t1_alu", out_alu, 32'(i));
    end
    drain;

    // Back-pressure into the skid entry
    send(32'hA, 5'd2, 1'b1);
    out_ready = 1'b0;
    in_valid = 1'b1; in_alu = 32'hB; in_mem = ~32'hB; in_ctrl = 3'h3; in_rd = 5'd2; in_regwrite = 1'b1;
    @(negedge clk);
    chk("t2_skid_accept", 32'(in_ready), 32'd1);
    sb.push_back('{rw: 1'b1, ctrl: 3'h3, alu: 32'hB, mem: ~32'hB, rd: 5'd2});
    step;
    chk("t2_in_ready_low", 32'(in_ready), 32'd0);
    in_alu = 32'hC; in_mem = ~32'hC; in_ctrl = 3'h4;
    step;
    step;
    chk("t2_stall3", 32'(stall_cnt), 32'd3);
    chk("t2_hold_main", out_alu, 32'hA);
    chk("t2_still_full", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    send(32'hC, 5'd2, 1'b1);
    drain;

    // x0 write suppression
    send(32'h55, 5'd0, 1'b1);
    chk("t3_valid", 32'(out_valid), 32'd1);
    chk("t3_alu", out_alu, 32'h55);
    chk("t3_x0_regwrite", 32'(out_regwrite), 32'd0);
    send(32'h66, 5'd7, 1'b1);
    chk("t3_rd7_regwrite", 32'(out_regwrite), 32'd1);
    drain;

    // Flush with both entries full and a concurrent offer
    out_ready = 1'b0;
    send(32'h11, 5'd3, 1'b1);
    send(32'h22, 5'd4, 1'b1);
    chk("t4_full", 32'(in_ready), 32'd0);
    chk("t4_main", out_alu, 32'h11);
    flush = 1'b1; in_valid = 1'b1; in_alu = 32'h99; in_rd = 5'd1; in_regwrite = 1'b1;
    step;
    flush = 1'b0; in_valid = 1'b0;
    sb.delete();
    chk("t4_out_valid", 32'(out_valid), 32'd0);
    chk("t4_in_ready", 32'(in_ready), 32'd1);
    chk("t4_regwrite", 32'(out_regwrite), 32'd0);
    out_ready = 1'b1;
    repeat (4) step;
    chk("t4_no_99", 32'(out_valid), 32'd0);

    // Stall counter saturation
    reset = 1'b1;
    step;
    reset = 1'b0;
    sb.delete();
    chk("t5_stall_clr", 32'(stall_cnt), 32'd0);
    out_ready = 1'b0;
    send(32'h77, 5'd3, 1'b1);
    chk("t5_stall_start", 32'(stall_cnt), 32'd0);
    for (int i = 1; i <= 20; i++) begin
      step;
      if (i == 10) chk("t5_stall10", 32'(stall_cnt), 32'd10);
      if (i == 15) chk("t5_stall15", 32'(stall_cnt), 32'd15);
      if (i == 20) chk("t5_stall_sat", 32'(stall_cnt), 32'd15);
    end
    flush = 1'b1;
    step;
    flush = 1'b0;
    sb.delete();
    chk("t5_flush_keeps", 32'(stall_cnt), 32'd15);
    chk("t5_flush_empty", 32'(out_valid), 32'd0);

    // Asynchronous reset mid-cycle with both entries full
    send(32'h31, 5'd1, 1'b1);
    send(32'h32, 5'd2, 1'b1);
    chk("t6_full", 32'(in_ready), 32'd0);
    chk("t6_pre_valid", 32'(out_valid), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_async_valid", 32'(out_valid), 32'd0);
    chk("t6_async_regwrite", 32'(out_regwrite), 32'd0);
    chk("t6_async_stall", 32'(stall_cnt), 32'd0);
    chk("t6_async_ready", 32'(in_ready), 32'd1);
    sb.delete();
    step;
    reset = 1'b0;
    out_ready = 1'b1;
    send(32'h41, 5'd9, 1'b1);
    drain;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/pipe_reg_skid.md
Name: pipe_reg_skid

Overview:
Parametrised, flow-controlled pipeline stage register, successor to the fixed-width stage registers between pipeline stages. It carries a write-back payload (result, load data, control field, destination register, register-write enable) with a valid/ready handshake. A 2-entry skid buffer gives full throughput with a registered in_ready. It adds synchronous flush, x0-write suppression and a saturating stall counter. It is instantiated between stages wherever back-pressure or squash is needed.

Parameters:
DATA_W, 32, width of each data word (in_alu, in_mem).
CTRL_W, 3, width of write-back select/control field.
RD_W, 5, destination register index width.
CNT_W, 16, stall counter width.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
flush  input  1  synchronous squash of all held entries
in_valid  input  1  upstream entry valid
in_ready  output  1  stage can accept; registered, equals NOT skid_valid
in_regwrite  input  1  register-write enable
in_ctrl  input  CTRL_W  write-back control
in_alu  input  DATA_W  ALU result
in_mem  input  DATA_W  memory read data
in_rd  input  RD_W  destination index
out_valid  output  1  output entry valid
out_ready  input  1  downstream accepts
out_regwrite  output  1  register-write enable; 0 whenever out_valid=0
out_ctrl  output  CTRL_W  held control
out_alu  output  DATA_W  held ALU result
out_mem  output  DATA_W  held read data
out_rd  output  RD_W  held destination
stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0

Behaviour:
- Storage: main entry (drives out_*) and skid entry. Each entry has a valid bit.
- Reset (async, active-high): both valid bits 0; all payload regs 0; stall_cnt 0; in_ready=1; out_regwrite=0. Reset asserted mid-transfer drops all entries immediately.
- Accept: the stage accepts when in_valid=1 and in_ready=1. Output transfer occurs when out_valid=1 and out_ready=1.
- On capture, the stored regwrite is in_regwrite AND (in_rd != 0). x0 writes are never issued.
- Per-cycle update (flush=0):
  - main empty, accept: input goes to main. Data visible at out_* the next cycle (1-cycle latency).
  - main full, output transfer, skid empty, accept: input goes to main.
  - main full, output transfer, skid full: skid moves to main. in_ready rises the next cycle.
  - main full, no output transfer, accept: input goes to skid. in_ready falls the next cycle.
  - main full, output transfer, no accept: main empties (skid is empty in this case).
- A simultaneous accept and output transfer yields sustained 1 entry/cycle throughput with no bubbles.
- Ordering: strict FIFO. Skid always drains into main before any newer entry.
- Flush=1: both valid bits 0 at the next edge. Any accept in the same cycle is discarded. The output transfer in that cycle still counts as delivered to the downstream stage. Payload regs need not clear. Flush has priority over all updates.
- out_regwrite = main_valid AND stored regwrite. Bubbles never write.
- stall_cnt increments by 1 each cycle with out_valid=1 and out_ready=0. It saturates at 2^CNT_W-1 and clears only on reset. Flush does not clear it.
- in_ready depends only on register state (no combinational path from out_ready).
- Invariant: skid_valid=1 implies main_valid=1.

Test Plan:
1. Reset held, then released; in_valid=1 every cycle with alu=1,2,3…, rd=1, out_ready=1 -> out_valid rises 1 cycle after the first accept. out_alu follows 1,2,3… with no gaps. in_ready stays 1.
2. Main holds alu=0xA. Drop out_ready for 3 cycles while offering alu=0xB,0xC -> 0xB captured into skid, in_ready=0 from the next cycle, 0xC held upstream. stall_cnt=3. Raise out_ready -> outputs 0xA,0xB,0xC in order.
3. Offer in_rd=0, in_regwrite=1, alu=0x55 -> out_valid=1, out_alu=0x55, out_regwrite=0. With in_rd=7 -> out_regwrite=1.
4. Both entries full; pulse flush with in_valid=1 (alu=0x99) -> next cycle out_valid=0, in_ready=1, out_regwrite=0. 0x99 never appears.
5. CNT_W=4, out_valid=1, out_ready=0 for 20 cycles -> stall_cnt reaches 15 and holds. A flush leaves it at 15.
6. Assert reset asynchronously between edges while both entries are full -> out_valid, out_regwrite, stall_cnt go to 0 and in_ready goes to 1 immediately, without waiting for a clock edge.
